uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning s_tick pulses per start, data or parity bit; legal when >= 2.
REQ-003 SHALL have parameter STOP_TICKS, default 16, meaning s_tick pulses in the stop period (16, 24 and 32 give 1, 1.5 and 2 stop bits at OVERSAMPLE=16).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries; legal when a power of 2 and >= 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port s_tick, input, 1 bit: one-clk-wide oversample strobe.
REQ-008 SHALL have port tx_data, input, DATA_BITS wide: byte to enqueue.
REQ-009 SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-010 SHALL have port tx_ready, output, 1 bit: the FIFO can accept data; equals !full.
REQ-011 SHALL have port parity_odd, input, 1 bit: 1 selects odd parity, 0 selects even; present only with UART_TX_PARITY_EN.
REQ-012 SHALL have port tx, output, 1 bit: registered serial line, LSB first.
REQ-013 SHALL have port tx_busy, output, 1 bit: state != IDLE.
REQ-014 SHALL have port tx_done, output, 1 bit: one-clk pulse at the end of each frame.
REQ-015 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH+1) bits: number of FIFO entries occupied.

Function
REQ-016 SHALL accept a push on each clk edge where tx_valid && tx_ready; a push while tx_ready=0 is ignored and data is dropped.
REQ-017 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 SHALL, in IDLE with the FIFO non-empty, pop the head, load the shift register, clear the tick and bit counters, capture parity_odd and enter START, all on one edge.
REQ-019 SHALL apply a latency from a push into an empty idle FIFO at edge N to a pop at edge N+1 and tx=0 after edge N+1.
REQ-020 SHALL advance the tick counter only on s_tick; a bit ends on the s_tick at which the counter equals OVERSAMPLE-1 (STOP_TICKS-1 in STOP), and the counter then clears.
REQ-021 SHALL drive tx: START=0; DATA=shift_reg[0], shifting right at each bit end; PARITY=(^frame data) XOR parity_odd_captured; STOP=1; IDLE=1.
REQ-022 SHALL go DATA -> PARITY (macro defined) or DATA -> STOP (macro undefined) at the end of bit DATA_BITS-1.
REQ-023 SHALL, at the end of STOP, pulse tx_done for one clk, then go directly to START (popping the head) if the FIFO is non-empty, with no idle bit; otherwise go to IDLE.
REQ-024 SHALL ignore s_tick in IDLE; a tick coincident with the pop edge is not counted.
REQ-025 SHALL allow push and pop on the same edge when the FIFO is non-empty and not full, leaving fifo_count unchanged.
REQ-026 SHALL wrap the FIFO pointers modulo FIFO_DEPTH; full when count==FIFO_DEPTH, empty when count==0.
REQ-027 SHALL size the tick counter as $clog2(max(OVERSAMPLE,STOP_TICKS)) and the bit counter as $clog2(DATA_BITS).

Reset
REQ-028 SHALL, while reset=1, force state=IDLE, tx=1, tx_done=0, tx_busy=0, fifo_count=0, tx_ready=1, pointers=0 and counters=0.
REQ-029 SHALL abort a frame on reset mid-frame, flush the queued bytes, and return tx to 1 immediately without waiting for a clk edge.

Configuration
REQ-030 SHALL compile in the parity port, the PARITY state and the parity bit when macro UART_TX_PARITY_EN is defined; when it is undefined, frames are start+data+stop, and the parity_odd port and the PARITY state do not exist.

Structure
REQ-031 SHALL take the tx state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3 bits) and the max() helper constant function from the shared package uart_pkg.
REQ-032 SHALL instantiate one sub-module, uart_sync_fifo (parameters WIDTH and DEPTH, push/pop/full/empty/count), for the transmit queue.

Verification
REQ-033 SHALL cover: defaults, push 0xA5 with s_tick every 4 clk -> tx shows 0, 1,0,1,0,0,1,0,1, 1, each bit 16 ticks long, then one tx_done pulse.
REQ-034 SHALL cover: macro on, parity_odd=0, push 0x07 -> parity bit 1; parity_odd=1 -> parity bit 0.
REQ-035 SHALL cover: push 0x11, 0x22, 0x33 back-to-back -> three contiguous frames, no idle gap, three tx_done pulses, fifo_count peaks at 2.
REQ-036 SHALL cover: FIFO_DEPTH=4 with 6 pushes during a frame -> tx_ready=0 after the 4th queued byte, the extra byte is dropped, and exactly 5 frames are sent.
REQ-037 SHALL cover: STOP_TICKS=32 -> stop high for 32 ticks; DATA_BITS=5 with 0x1F -> 5 ones.
REQ-038 SHALL cover: reset asserted in DATA of bit 3 -> tx=1 at once, fifo_count=0, no tx_done, and the next push transmits a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and a constant max() helper.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_e;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO for the UART transmit queue; pushes while full and pops while
// empty are ignored, pointers wrap modulo DEPTH (a power of 2).
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // NOTE: the storage array is deliberately not reset; count and pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; back-to-back frames leave no idle bit.
// Define UART_TX_PARITY_EN to add the parity_odd port and a parity bit per frame.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_TICKS = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            s_tick,
  input  logic [DATA_BITS-1:0]            tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
`ifdef UART_TX_PARITY_EN
  input  logic                            parity_odd,
`endif
  output logic                            tx,
  output logic                            tx_busy,
  output logic                            tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int TW = $clog2(max(OVERSAMPLE, STOP_TICKS));
  localparam int BW = $clog2(DATA_BITS);

  tx_state_e            r_state;
  tx_state_e            w_state_nxt;
  logic [TW-1:0]        r_tick_cnt;
  logic [TW-1:0]        w_tick_nxt;
  logic [BW-1:0]        r_bit_cnt;
  logic [BW-1:0]        w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 r_tx_done;
  logic                 w_pop;
  logic                 w_bit_end;
  logic                 w_last_bit;
  logic [DATA_BITS-1:0] w_fifo_data;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity_bit;
`endif

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (tx_valid),
    .i_pop   (w_pop),
    .i_data  (tx_data),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (fifo_count)
  );

  // A bit ends on the tick that completes its oversample (or stop) period.
  assign w_bit_end  = s_tick && ((r_state == STOP) ? (r_tick_cnt == TW'(STOP_TICKS - 1))
                                                    : (r_tick_cnt == TW'(OVERSAMPLE - 1)));
  assign w_last_bit = (r_bit_cnt == BW'(DATA_BITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: if (!w_fifo_empty) begin
        w_state_nxt = START;
        w_pop       = 1'b1;
      end
      START: if (w_bit_end) w_state_nxt = DATA;
      DATA: if (w_bit_end && w_last_bit) begin
`ifdef UART_TX_PARITY_EN
        w_state_nxt = PARITY;
`else
        w_state_nxt = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (w_bit_end) w_state_nxt = STOP;
`endif
      STOP: if (w_bit_end) begin
        if (!w_fifo_empty) begin
          w_state_nxt = START;
          w_pop       = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    if (w_pop) begin
      w_tick_nxt  = '0;
      w_bit_nxt   = '0;
      w_shift_nxt = w_fifo_data;
    end else if (r_state != IDLE && s_tick) begin
      w_tick_nxt = w_bit_end ? '0 : r_tick_cnt + TW'(1);
      if (r_state == DATA && w_bit_end) begin
        w_bit_nxt   = r_bit_cnt + BW'(1);
        w_shift_nxt = r_shift >> 1;
      end
    end
  end

  // The line is registered from the next state so it changes on the same edge as the FSM.
  always_comb begin
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_nxt = r_parity_bit;
`endif
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_tx_done  <= (r_state == STOP) && w_bit_end;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_parity_bit <= 1'b0;
    else if (w_pop) r_parity_bit <= (^w_fifo_data) ^ parity_odd;
  end
`endif

  assign tx       = r_tx;
  assign tx_done  = r_tx_done;
  assign tx_busy  = (r_state != IDLE);
  assign tx_ready = !w_fifo_full;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (default and 5-bit/32-tick stop/depth 2),
// background line decoders and per-scenario tests against a byte-queue model.
module tb_uart_tx_fifo;

  localparam int OS     = 16;
  localparam int DB     = 8;
  localparam int ST     = 16;
  localparam int DEPTH  = 4;
  localparam int DB2    = 5;
  localparam int ST2    = 32;
  localparam int DEPTH2 = 2;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           s_tick = 1'b0;
  logic [DB-1:0]  tx_data = '0;
  logic           tx_valid = 1'b0;
  logic           tx_ready, tx, tx_busy, tx_done;
  logic [2:0]     fifo_count;
  logic [DB2-1:0] tx_data2 = '0;
  logic           tx_valid2 = 1'b0;
  logic           tx_ready2, tx2, tx_busy2, tx_done2;
  logic [1:0]     fifo_count2;
`ifdef UART_TX_PARITY_EN
  logic           parity_odd = 1'b0;
  logic           parity_odd2 = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int done0 = 0;
  int done1 = 0;

  typedef struct packed {
    logic [8:0] data;
    logic       par;
    logic       shape_ok;
    int         gap;
  } frame_t;

  frame_t rxq0[$];
  frame_t rxq1[$];

  uart_tx_fifo #(
    .DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_TICKS(ST), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done), .fifo_count(fifo_count)
  );

  uart_tx_fifo #(
    .DATA_BITS(DB2), .OVERSAMPLE(OS), .STOP_TICKS(ST2), .FIFO_DEPTH(DEPTH2)
  ) dut2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd2),
`endif
    .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2), .fifo_count(fifo_count2)
  );

  always #5 clk = ~clk;

  // s_tick every 4th clock, changed just after the edge so it is stable at negedge.
  initial begin
    int c = 0;
    forever begin
      @(posedge clk);
      #1;
      c = (c + 1) % 4;
      s_tick = (c == 0);
    end
  end

  always @(negedge clk) begin
    if (tx_done)  done0++;
    if (tx_done2) done1++;
  end

  task automatic get_sample(input int which, output logic v, output bit rs);
    rs = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (reset) rs = 1'b1;
      if (s_tick) break;
    end
    v = (which == 0) ? tx : tx2;
  endtask

  // Line decoder: one sample per counted tick; a frame is a fixed-length run of samples.
  task automatic decode_loop(input int which, input int db, input int st);
    int gap = 0;
    forever begin
      logic   v;
      bit     rs;
      bit     abort;
      logic   q[$];
      frame_t f;
      int     nb;
      get_sample(which, v, rs);
      if (rs) gap = 0;
      else if (v) gap++;
      else begin
        q = {v};
        abort = 1'b0;
        nb = OS * (1 + db + PB) + st;
        for (int k = 1; k < nb; k++) begin
          get_sample(which, v, rs);
          if (rs) begin abort = 1'b1; break; end
          q.push_back(v);
        end
        if (!abort) begin
          f = '0;
          f.shape_ok = 1'b1;
          f.gap = gap;
          for (int b = 0; b < 1 + db + PB; b++)
            for (int j = 0; j < OS; j++)
              if (q[b*OS+j] !== q[b*OS]) f.shape_ok = 1'b0;
          for (int j = 0; j < st; j++)
            if (q[(1+db+PB)*OS+j] !== 1'b1) f.shape_ok = 1'b0;
          for (int i = 0; i < db; i++) f.data[i] = q[(1+i)*OS];
          if (PB == 1) f.par = q[(1+db)*OS];
          if (which == 0) rxq0.push_back(f);
          else            rxq1.push_back(f);
        end
        gap = 0;
      end
    end
  endtask

  initial decode_loop(0, DB, ST);
  initial decode_loop(1, DB2, ST2);

  task automatic drive(input int which, input logic v, input logic [8:0] d);
    if (which == 0) begin tx_valid = v;  tx_data = d[DB-1:0];   end
    else            begin tx_valid2 = v; tx_data2 = d[DB2-1:0]; end
  endtask

  task automatic push_bytes(input int which, input logic [8:0] b[$]);
    foreach (b[i]) begin
      drive(which, 1'b1, b[i]);
      @(negedge clk);
    end
    drive(which, 1'b0, 9'h0);
  endtask

  task automatic wait_frames(input int which, input int n, output int peak);
    int lim = n * 800 + 400;
    peak = 0;
    while ((((which == 0) ? rxq0.size() : rxq1.size()) < n) && lim > 0) begin
      @(negedge clk);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      lim--;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (tx !== 1'b1)          begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    total++; if (tx_busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    total++; if (tx_done !== 1'b0)     begin bad++; $display("FAIL reset_done: got %b want 0", tx_done); end
    total++; if (fifo_count !== 3'd0)  begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    total++; if (tx_ready !== 1'b1)    begin bad++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
    total++; if (tx2 !== 1'b1)         begin bad++; $display("FAIL reset_tx2: got %b want 1", tx2); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // 0xA5 pushed so that the pop edge carries an s_tick, which must not be counted.
  task automatic test_latency();
    int d0 = done0;
    int pk;
    frame_t f;
    rxq0.delete();
    for (int n = 0; n < 8 && !s_tick; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    drive(0, 1'b1, 9'h0A5);
    @(negedge clk);
    drive(0, 1'b0, 9'h0);
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL lat_count_push: got %0d want 1", fifo_count); end
    total++; if (tx !== 1'b1)         begin bad++; $display("FAIL lat_tx_push: got %b want 1", tx); end
    @(negedge clk);
    total++; if (tx !== 1'b0)         begin bad++; $display("FAIL lat_tx_pop: got %b want 0", tx); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL lat_count_pop: got %0d want 0", fifo_count); end
    total++; if (tx_busy !== 1'b1)    begin bad++; $display("FAIL lat_busy: got %b want 1", tx_busy); end
    wait_frames(0, 1, pk);
    total++;
    if (rxq0.size() != 1) begin bad++; $display("FAIL lat_frames: got %0d want 1", rxq0.size()); end
    else begin
      f = rxq0.pop_front();
      if (f.data !== 9'h0A5 || !f.shape_ok) begin
        bad++; $display("FAIL lat_frame: got data=%0h shape=%b want data=a5 shape=1", f.data, f.shape_ok);
      end
    end
    total++; if (done0 - d0 != 1) begin bad++; $display("FAIL lat_done: got %0d pulses want 1", done0 - d0); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL lat_idle: got busy=%b want 0", tx_busy); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [8:0] bq[$];
    logic [8:0] d;
    logic       po;
    logic       exp_par;
    int         pk;
    frame_t     f;
    for (int i = 0; i < 3; i++) begin
      rxq0.delete();
      d  = (i < 2) ? 9'h007 : 9'($urandom_range(0, 255));
      po = (i < 2) ? i[0] : 1'($urandom_range(0, 1));
      exp_par = (^d[7:0]) ^ po;
      parity_odd = po;
      bq = {d};
      push_bytes(0, bq);
      wait_frames(0, 1, pk);
      total++;
      if (rxq0.size() != 1) begin bad++; $display("FAIL par_frames: got %0d want 1", rxq0.size()); end
      else begin
        f = rxq0.pop_front();
        if (f.par !== exp_par || f.data !== d || !f.shape_ok) begin
          bad++; $display("FAIL par_bit: got par=%b data=%0h shape=%b want par=%b data=%0h", f.par, f.data, f.shape_ok, exp_par, d);
        end
      end
    end
    parity_odd = 1'b0;
  endtask
`endif

  task automatic test_back_to_back();
    logic [8:0] bq[$];
    int d0 = done0;
    int pk;
    frame_t f;
    rxq0.delete();
    bq = {9'h011, 9'h022, 9'h033};
    push_bytes(0, bq);
    wait_frames(0, 3, pk);
    total++; if (pk != 2) begin bad++; $display("FAIL b2b_peak: got %0d want 2", pk); end
    total++; if (rxq0.size() != 3) begin bad++; $display("FAIL b2b_frames: got %0d want 3", rxq0.size()); end
    for (int i = 0; i < 3; i++) begin
      if (rxq0.size() == 0) break;
      f = rxq0.pop_front();
      total++;
      if (f.data !== bq[i] || !f.shape_ok || (i > 0 && f.gap != 0)) begin
        bad++; $display("FAIL b2b_frame%0d: got data=%0h shape=%b gap=%0d want data=%0h gap=0", i, f.data, f.shape_ok, f.gap, bq[i]);
      end
    end
    total++; if (done0 - d0 != 3) begin bad++; $display("FAIL b2b_done: got %0d want 3", done0 - d0); end
  endtask

  task automatic test_overflow();
    logic [8:0] b[6];
    logic       exp_ready;
    int d0 = done0;
    int pk;
    frame_t f;
    rxq0.delete();
    for (int i = 0; i < 6; i++) begin
      b[i] = 9'($urandom_range(0, 255));
      exp_ready = (((i == 0) ? 0 : i - 1) < DEPTH);
      total++;
      if (tx_ready !== exp_ready) begin bad++; $display("FAIL ovf_ready%0d: got %b want %b", i, tx_ready, exp_ready); end
      drive(0, 1'b1, b[i]);
      @(negedge clk);
    end
    drive(0, 1'b0, 9'h0);
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
    total++; if (tx_ready !== 1'b0)   begin bad++; $display("FAIL ovf_full: got %b want 0", tx_ready); end
    wait_frames(0, 5, pk);
    repeat (700) @(negedge clk);
    total++; if (rxq0.size() != 5) begin bad++; $display("FAIL ovf_frames: got %0d want 5", rxq0.size()); end
    for (int i = 0; i < 5; i++) begin
      if (rxq0.size() == 0) break;
      f = rxq0.pop_front();
      total++;
      if (f.data !== b[i] || !f.shape_ok) begin
        bad++; $display("FAIL ovf_frame%0d: got %0h shape=%b want %0h", i, f.data, f.shape_ok, b[i]);
      end
    end
    total++; if (done0 - d0 != 5) begin bad++; $display("FAIL ovf_done: got %0d want 5", done0 - d0); end
  endtask

  task automatic test_random();
    logic [8:0] bq[$];
    int k, d0, pk;
    frame_t f;
    for (int r = 0; r < 3; r++) begin
      rxq0.delete();
      bq.delete();
      d0 = done0;
      k = $urandom_range(1, DEPTH);
      for (int i = 0; i < k; i++) bq.push_back(9'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 7)) @(negedge clk);
      push_bytes(0, bq);
      wait_frames(0, k, pk);
      total++; if (rxq0.size() != k) begin bad++; $display("FAIL rnd_frames: got %0d want %0d", rxq0.size(), k); end
      for (int i = 0; i < k; i++) begin
        if (rxq0.size() == 0) break;
        f = rxq0.pop_front();
        total++;
        if (f.data !== bq[i] || !f.shape_ok || (i > 0 && f.gap != 0)) begin
          bad++; $display("FAIL rnd_frame%0d: got %0h shape=%b gap=%0d want %0h", i, f.data, f.shape_ok, f.gap, bq[i]);
        end
      end
      total++; if (done0 - d0 != k) begin bad++; $display("FAIL rnd_done: got %0d want %0d", done0 - d0, k); end
    end
  endtask

  task automatic test_narrow_long_stop();
    logic [8:0] bq[$];
    int d1 = done1;
    int pk;
    frame_t f;
    rxq1.delete();
    bq = {9'h01F, 9'($urandom_range(0, 31))};
    push_bytes(1, bq);
    wait_frames(1, 2, pk);
    total++; if (rxq1.size() != 2) begin bad++; $display("FAIL n5_frames: got %0d want 2", rxq1.size()); end
    for (int i = 0; i < 2; i++) begin
      if (rxq1.size() == 0) break;
      f = rxq1.pop_front();
      total++;
      if (f.data !== bq[i] || !f.shape_ok || (i > 0 && f.gap != 0)) begin
        bad++; $display("FAIL n5_frame%0d: got %0h shape=%b gap=%0d want %0h", i, f.data, f.shape_ok, f.gap, bq[i]);
      end
    end
    total++; if (done1 - d1 != 2) begin bad++; $display("FAIL n5_done: got %0d want 2", done1 - d1); end
  endtask

  task automatic test_mid_reset();
    logic [8:0] bq[$];
    int d0 = done0;
    int pk;
    frame_t f;
    rxq0.delete();
    bq = {9'h0C3, 9'h03C};
    push_bytes(0, bq);
    repeat (288) @(negedge clk);
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL mr_queued: got %0d want 1", fifo_count); end
    #1 reset = 1'b1;
    #1;
    total++; if (tx !== 1'b1)         begin bad++; $display("FAIL mr_tx: got %b want 1", tx); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL mr_count: got %0d want 0", fifo_count); end
    total++; if (tx_busy !== 1'b0)    begin bad++; $display("FAIL mr_busy: got %b want 0", tx_busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (800) @(negedge clk);
    total++; if (rxq0.size() != 0) begin bad++; $display("FAIL mr_no_frame: got %0d frames want 0", rxq0.size()); end
    total++; if (done0 != d0)      begin bad++; $display("FAIL mr_no_done: got %0d pulses want 0", done0 - d0); end
    bq = {9'h05A};
    push_bytes(0, bq);
    wait_frames(0, 1, pk);
    total++;
    if (rxq0.size() != 1) begin bad++; $display("FAIL mr_next_frames: got %0d want 1", rxq0.size()); end
    else begin
      f = rxq0.pop_front();
      if (f.data !== 9'h05A || !f.shape_ok) begin
        bad++; $display("FAIL mr_next: got %0h shape=%b want 5a", f.data, f.shape_ok);
      end
    end
    total++; if (done0 - d0 != 1) begin bad++; $display("FAIL mr_next_done: got %0d want 1", done0 - d0); end
  endtask

  initial begin
    test_reset();
    test_latency();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_overflow();
    test_random();
    test_narrow_long_stop();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
